// File: rtl/wb_master_single.sv
// Wishbone B4 classic single-transfer master: one READ or WRITE per accepted
// command, with a saturating ack timeout that reports an error response.
module wb_master_single #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // command side
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [7:0]            cmd_sel_i,
  input  logic                  cmd_we_i,
  // response side
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  // Wishbone master
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [7:0]            sel_o,
  output logic                  we_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  input  logic                  ack_i
);

  localparam int          LANES    = DATA_WIDTH / GRANULE;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    RESPOND
  } state_t;

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_cnt_inc;
  logic [DATA_WIDTH-1:0] rd_masked;

  // Read data keeps only the lanes the master selected; sel bits beyond the
  // last lane are never consulted.
  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sel_o[i]) rd_masked[i*GRANULE +: GRANULE] = dat_i[i*GRANULE +: GRANULE];
    end
  end

  assign tmo_cnt_inc = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments here would create races.
  always_ff @(posedge clk_i) begin
    // NOTE: rst_i is sampled only on the clock edge (synchronous); an ack seen
    // on the same edge is discarded because the reset branch takes priority.
    if (!rst_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      adr_o       <= '0;
      dat_o       <= '0;
      sel_o       <= '0;
      we_o        <= 1'b0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            state       <= REQUEST;
            cmd_ready_o <= 1'b0;
            adr_o       <= cmd_adr_i;
            dat_o       <= cmd_dat_i;
            sel_o       <= cmd_sel_i;
            we_o        <= cmd_we_i;
            cyc_o       <= 1'b1;
            stb_o       <= 1'b1;
            tmo_cnt     <= '0;
          end
        end

        REQUEST: begin
          if (ack_i) begin
            // An ack on the final timeout edge still counts as success.
            state       <= RESPOND;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= we_o ? '0 : rd_masked;
          end else begin
            tmo_cnt <= tmo_cnt_inc;
            if (tmo_cnt >= TMO_LAST) begin
              state       <= RESPOND;
              cyc_o       <= 1'b0;
              stb_o       <= 1'b0;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_dat_o   <= '0;
            end
          end
        end

        RESPOND: begin
          // rsp_dat_o / rsp_err_o hold until the next response is produced.
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          cyc_o       <= 1'b0;
          stb_o       <= 1'b0;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_single.sv
// Self-checking bench for wb_master_single: directed vector table, random
// transactions against a lane-mask reference model, and reset/back-to-back cases.
module tb_wb_master_single;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int GR  = 8;
  localparam int TMO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [DW-1:0] cmd_dat_i = '0;
  logic [7:0]    cmd_sel_i = '0;
  logic          cmd_we_i = 1'b0;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i = '0;
  logic [7:0]    sel_o;
  logic          we_o;
  logic          stb_o;
  logic          cyc_o;
  logic          ack_i = 1'b0;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  wb_master_single #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .GRANULE   (GR),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_sel_i  (cmd_sel_i),
    .cmd_we_i   (cmd_we_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .sel_o      (sel_o),
    .we_o       (we_o),
    .stb_o      (stb_o),
    .cyc_o      (cyc_o),
    .ack_i      (ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [7:0]    sel;
    logic          we;
    logic [DW-1:0] sdat;     // slave read data
    int            ack_edge; // REQUEST edge carrying ack, 0 = never
    logic [DW-1:0] exp_dat;
    logic          exp_err;
    int            exp_cyc;  // cycles with stb high
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Reference model: which REQUEST edge ends the transfer, and what data results.
  task automatic model(input logic [DW-1:0] sdat, input logic [7:0] sel, input logic we,
                       input int ack_edge, output logic [DW-1:0] exp_dat,
                       output logic exp_err, output int exp_cyc);
    logic [DW-1:0] lane_mask;
    exp_err = !(ack_edge >= 1 && ack_edge <= TMO);
    exp_cyc = exp_err ? TMO : ack_edge;
    exp_dat = '0;
    if (!exp_err && !we) begin
      for (int i = 0; i < DW / GR; i++) begin
        lane_mask = {{(DW-GR){1'b0}}, {GR{1'b1}}} << (i * GR);
        if (sel[i]) exp_dat = exp_dat | (sdat & lane_mask);
      end
    end
  endtask

  // Starts and ends at a negedge with the DUT idle. junk drives ack_i in
  // IDLE/RESPOND, where it must be ignored.
  task automatic run_txn(input vec_t v, input logic junk);
    int n;
    check("ready_in_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_adr_i   = v.adr;
    cmd_dat_i   = v.dat;
    cmd_sel_i   = v.sel;
    cmd_we_i    = v.we;
    dat_i       = v.sdat;
    ack_i       = junk;
    tick();
    cmd_valid_i = 1'b0;
    cmd_adr_i   = ~v.adr;
    cmd_dat_i   = ~v.dat;
    cmd_sel_i   = ~v.sel;
    cmd_we_i    = ~v.we;
    check("cyc_start", cyc_o, 1);
    check("stb_start", stb_o, 1);
    check("ready_busy", cmd_ready_o, 0);
    check("adr_o", adr_o, v.adr);
    check("dat_o", dat_o, v.dat);
    check("sel_o", sel_o, v.sel);
    check("we_o", we_o, v.we);
    n = 0;
    while (stb_o && n < TMO + 3) begin
      n++;
      ack_i = (n == v.ack_edge);
      tick();
      if (stb_o) check("adr_stable", adr_o, v.adr);
    end
    ack_i = junk;
    check("stb_cycles", n, v.exp_cyc);
    check("cyc_end", cyc_o, 0);
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_err", rsp_err_o, v.exp_err);
    check("rsp_dat", rsp_dat_o, v.exp_dat);
    check("sel_hold", sel_o, v.sel);
    tick();
    ack_i = 1'b0;
    check("rsp_valid_drop", rsp_valid_o, 0);
    check("stb_idle", stb_o, 0);
    check("ready_back", cmd_ready_o, 1);
    check("rsp_dat_hold", rsp_dat_o, v.exp_dat);
    check("rsp_err_hold", rsp_err_o, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          adr       dat           sel    we    sdat          ack exp_dat       err   cyc
    vecs[0] = '{16'h0010, 32'hDEADBEEF, 8'h0F, 1'b1, 32'h00000000, 3, 32'h00000000, 1'b0, 3};
    vecs[1] = '{16'h0020, 32'h00000000, 8'h05, 1'b0, 32'h11223344, 1, 32'h00220044, 1'b0, 1};
    vecs[2] = '{16'h0030, 32'h00000000, 8'h0F, 1'b0, 32'h99999999, 0, 32'h00000000, 1'b1, 4};
    vecs[3] = '{16'h0034, 32'h00000000, 8'h0F, 1'b0, 32'hCAFEF00D, 4, 32'hCAFEF00D, 1'b0, 4};
    vecs[4] = '{16'h0038, 32'h00000000, 8'hF3, 1'b0, 32'hA5A51234, 2, 32'h00001234, 1'b0, 2};
    vecs[5] = '{16'hFFFC, 32'h0BADF00D, 8'hFF, 1'b1, 32'h12345678, 0, 32'h00000000, 1'b1, 4};
    vecs[6] = '{16'h1234, 32'h00000000, 8'h0A, 1'b0, 32'h89ABCDEF, 2, 32'h8900CD00, 1'b0, 2};

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    check("rst_ready", cmd_ready_o, 1);
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_rsp_dat", rsp_dat_o, 0);

    // Directed vector table
    for (int i = 0; i < 7; i++) run_txn(vecs[i], 1'b1);

    // Reset during the second REQUEST cycle, with an ack on the reset edge
    cmd_valid_i = 1'b1;
    cmd_adr_i = 16'h0050; cmd_dat_i = '0; cmd_sel_i = 8'h0F; cmd_we_i = 1'b0;
    dat_i = 32'h76543210;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
    ack_i = 1'b1;
    tick();
    rst_i = 1'b1;
    ack_i = 1'b0;
    check("mid_rst_cyc", cyc_o, 0);
    check("mid_rst_stb", stb_o, 0);
    check("mid_rst_rsp_valid", rsp_valid_o, 0);
    check("mid_rst_ready", cmd_ready_o, 1);
    tick();
    check("mid_rst_no_rsp", rsp_valid_o, 0);
    v = '{16'h0050, 32'h0, 8'h0F, 1'b0, 32'h76543210, 2, 32'h76543210, 1'b0, 2};
    run_txn(v, 1'b0);

    // Back-to-back: cmd_valid held high across two commands, register slave
    // acks whenever stb is high (write then read back the same word).
    cmd_valid_i = 1'b1;
    cmd_adr_i = 16'h0040; cmd_dat_i = 32'h55667788; cmd_sel_i = 8'h0F; cmd_we_i = 1'b1;
    tick();
    check("b2b_a_stb", stb_o, 1);
    check("b2b_a_we", we_o, 1);
    cmd_adr_i = 16'h0040; cmd_dat_i = 32'h0; cmd_sel_i = 8'h0F; cmd_we_i = 1'b0;
    ack_i = stb_o;
    dat_i = 32'h0;
    tick();
    ack_i = 1'b0;
    dat_i = 32'h55667788;  // slave register now holds the written word
    check("b2b_gap1_stb", stb_o, 0);
    check("b2b_a_rsp", rsp_valid_o, 1);
    check("b2b_gap1_ready", cmd_ready_o, 0);
    tick();
    check("b2b_gap2_stb", stb_o, 0);
    check("b2b_gap2_ready", cmd_ready_o, 1);
    tick();
    check("b2b_b_stb", stb_o, 1);
    check("b2b_b_we", we_o, 0);
    cmd_valid_i = 1'b0;
    ack_i = stb_o;
    tick();
    ack_i = 1'b0;
    check("b2b_b_rsp", rsp_valid_o, 1);
    check("b2b_b_dat", rsp_dat_o, 32'h55667788);
    check("b2b_b_err", rsp_err_o, 0);
    tick();
    check("b2b_done_ready", cmd_ready_o, 1);

    // Random transactions against the reference model
    for (int i = 0; i < 60; i++) begin
      v.adr      = AW'($urandom);
      v.dat      = $urandom;
      v.sel      = 8'($urandom);
      v.we       = 1'($urandom);
      v.sdat     = $urandom;
      v.ack_edge = int'($urandom_range(0, TMO + 2));
      model(v.sdat, v.sel, v.we, v.ack_edge, v.exp_dat, v.exp_err, v.exp_cyc);
      run_txn(v, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
